index_read_port: RTL and testbench

Register-read responder for the lane's index request stream. Each accepted request (req, slice flag, index) reads one entry of a lane-local register file. The result is queued in a small output FIFO and delivered downstream with a valid/stall handshake. The block sits directly behind the per-lane index generator, tracks slice runs, and throttles the generator through a stall output when its FIFO nears full.

---
 rtl/index_read_port_if.sv | 35 +++
 rtl/index_read_port.sv | 171 +++++++++++++++++
 tb/tb_index_read_port.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/index_read_port_if.sv
// Request, register-write and downstream result signals of index_read_port.
// The master side is the index generator / consumer; the slave side is the responder.
interface index_read_port_if #(
    parameter int WIDTH_INDEX = 8,
    parameter int WIDTH_DATA  = 32
);
    logic                   I_Req;
    logic                   I_Slice;
    logic [WIDTH_INDEX-1:0] I_Index;
    logic                   O_Stall;
    logic                   I_We;
    logic [WIDTH_INDEX-1:0] I_Wr_Index;
    logic [WIDTH_DATA-1:0]  I_Wr_Data;
    logic                   I_Stall;
    logic                   O_Valid;
    logic [WIDTH_DATA-1:0]  O_Data;
    logic [WIDTH_INDEX-1:0] O_Index;
    logic                   O_Slice;
    logic                   O_First;
    logic                   O_Err;
    logic                   O_Run_Done;
    logic [WIDTH_INDEX:0]   O_Run_Len;

    modport master (
        output I_Req, I_Slice, I_Index, I_We, I_Wr_Index, I_Wr_Data, I_Stall,
        input  O_Stall, O_Valid, O_Data, O_Index, O_Slice, O_First, O_Err,
               O_Run_Done, O_Run_Len
    );

    modport slave (
        input  I_Req, I_Slice, I_Index, I_We, I_Wr_Index, I_Wr_Data, I_Stall,
        output O_Stall, O_Valid, O_Data, O_Index, O_Slice, O_First, O_Err,
               O_Run_Done, O_Run_Len
    );
endinterface

// File: rtl/index_read_port.sv
// Lane register-read responder: reads the register file per accepted request, queues results in a FIFO.
// Optional macro INDEX_READ_BYPASS_EN makes a same-cycle write to the read index visible (write-first).
module index_read_port #(
    parameter int WIDTH_INDEX = 8,
    parameter int WIDTH_DATA  = 32,
    parameter int NUM_ENTRY   = 256,
    parameter int FIFO_DEPTH  = 4
) (
    input logic               clock,
    input logic               reset,
    index_read_port_if.slave  bus
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ADDR_W = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1;
    localparam int LEN_W  = WIDTH_INDEX + 1;

    localparam logic [LEN_W-1:0] ENTRY_LIMIT = LEN_W'(NUM_ENTRY);
    localparam logic [CNT_W-1:0] STALL_LEVEL = CNT_W'(FIFO_DEPTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    typedef struct packed {
        logic [WIDTH_DATA-1:0]  data;
        logic [WIDTH_INDEX-1:0] index;
        logic                   slice;
        logic                   first;
        logic                   err;
    } entry_t;

    logic [WIDTH_DATA-1:0] regFile [NUM_ENTRY];
    entry_t                fifoMem [FIFO_DEPTH];

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_t           state_q, state_d;
    logic [LEN_W-1:0] runCnt_q, runCnt_d;
    logic             runDone_q, runDone_d;
    logic [LEN_W-1:0] runLen_q, runLen_d;

    logic                  stall;
    logic                  accept;
    logic                  headValid;
    logic                  pop;
    logic                  rdInRange;
    logic                  wrInRange;
    logic                  firstFlag;
    logic [WIDTH_DATA-1:0] arrayData;
    logic [WIDTH_DATA-1:0] readData;
    entry_t                pushEntry;
    entry_t                head;

    assign stall     = (count_q >= STALL_LEVEL);
    assign accept    = bus.I_Req & ~stall;
    assign headValid = (count_q != '0);
    assign pop       = headValid & ~bus.I_Stall;
    assign rdInRange = ({1'b0, bus.I_Index} < ENTRY_LIMIT);
    assign wrInRange = ({1'b0, bus.I_Wr_Index} < ENTRY_LIMIT);
    assign arrayData = regFile[bus.I_Index[ADDR_W-1:0]];

`ifdef INDEX_READ_BYPASS_EN
    assign readData = (bus.I_We && (bus.I_Wr_Index == bus.I_Index)) ? bus.I_Wr_Data : arrayData;
`else
    assign readData = arrayData;
`endif

    always_comb begin
        pushEntry.data  = rdInRange ? readData : '0;
        pushEntry.index = bus.I_Index;
        pushEntry.slice = bus.I_Slice;
        pushEntry.first = firstFlag;
        pushEntry.err   = ~rdInRange;
    end

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (accept) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // A run stays open while stalled, since the generator is still holding its next element.
    always_comb begin
        state_d   = state_q;
        runCnt_d  = runCnt_q;
        runDone_d = 1'b0;
        runLen_d  = runLen_q;
        firstFlag = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && bus.I_Slice) begin
                    state_d   = RUN;
                    runCnt_d  = LEN_W'(1);
                    firstFlag = 1'b1;
                end
            end
            RUN: begin
                if (accept && bus.I_Slice) begin
                    if (runCnt_q != '1) begin
                        runCnt_d = runCnt_q + LEN_W'(1);
                    end
                end else if (!stall) begin
                    state_d   = IDLE;
                    runDone_d = 1'b1;
                    runLen_d  = runCnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            runCnt_q  <= '0;
            runDone_q <= 1'b0;
            runLen_q  <= '0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            runCnt_q  <= runCnt_d;
            runDone_q <= runDone_d;
            runLen_q  <= runLen_d;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            fifoMem[wrPtr_q] <= pushEntry;
        end
    end

    always_ff @(posedge clock) begin
        if (bus.I_We && wrInRange) begin
            regFile[bus.I_Wr_Index[ADDR_W-1:0]] <= bus.I_Wr_Data;
        end
    end

    // Head fields are gated so an empty FIFO presents all-zero outputs.
    assign head           = fifoMem[rdPtr_q];
    assign bus.O_Stall    = stall;
    assign bus.O_Valid    = headValid;
    assign bus.O_Data     = headValid ? head.data  : '0;
    assign bus.O_Index    = headValid ? head.index : '0;
    assign bus.O_Slice    = headValid & head.slice;
    assign bus.O_First    = headValid & head.first;
    assign bus.O_Err      = headValid & head.err;
    assign bus.O_Run_Done = runDone_q;
    assign bus.O_Run_Len  = runLen_q;

endmodule

// File: tb/tb_index_read_port.sv
// Testbench for index_read_port: directed scenarios then randomized traffic against a queue-based reference model.
module tb_index_read_port;

    localparam int WI = 9;
    localparam int WD = 32;
    localparam int NE = 256;
    localparam int FD = 4;
`ifdef INDEX_READ_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        int          index;
        bit          slice;
        bit          first;
        bit          err;
        bit          known;
    } exp_t;

    logic clock;
    logic reset;

    index_read_port_if #(.WIDTH_INDEX(WI), .WIDTH_DATA(WD)) bus ();

    index_read_port #(
        .WIDTH_INDEX(WI),
        .WIDTH_DATA (WD),
        .NUM_ENTRY  (NE),
        .FIFO_DEPTH (FD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          total = 0;
    int          bad = 0;
    exp_t        expQ[$];
    logic [31:0] mdlMem [NE];
    bit          mdlWritten [NE];
    bit          inRun = 0;
    int          runLen = 0;
    bit          expDone = 0;
    int          expLen = 0;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t h;
        checkVal("stall", 64'(bus.O_Stall), 64'(expQ.size() >= FD - 1));
        checkVal("valid", 64'(bus.O_Valid), 64'(expQ.size() > 0));
        if (expQ.size() > 0) begin
            h = expQ[0];
            checkVal("index", 64'(bus.O_Index), 64'(h.index));
            checkVal("slice", 64'(bus.O_Slice), 64'(h.slice));
            checkVal("first", 64'(bus.O_First), 64'(h.first));
            checkVal("err", 64'(bus.O_Err), 64'(h.err));
            if (h.known) checkVal("data", 64'(bus.O_Data), 64'(h.data));
        end else begin
            checkVal("idle_data", 64'(bus.O_Data), 64'd0);
        end
        checkVal("run_done", 64'(bus.O_Run_Done), 64'(expDone));
        if (expDone) checkVal("run_len", 64'(bus.O_Run_Len), 64'(expLen));
    endtask

    // Drives one cycle at the falling edge, advances the model across the rising edge, then checks.
    task automatic applyStimulus(input bit req, input bit slc, input int idx, input bit we,
                                 input int widx, input logic [31:0] wdata, input bit dstall,
                                 output bit accepted);
        bit   stallNow;
        exp_t e;
        bus.I_Req      = req;
        bus.I_Slice    = slc;
        bus.I_Index    = idx[WI-1:0];
        bus.I_We       = we;
        bus.I_Wr_Index = widx[WI-1:0];
        bus.I_Wr_Data  = wdata;
        bus.I_Stall    = dstall;

        stallNow = (expQ.size() >= FD - 1);
        accepted = req && !stallNow;
        e.index  = idx;
        e.slice  = slc;
        e.first  = accepted && slc && !inRun;
        e.err    = (idx >= NE);
        if (e.err) begin
            e.data  = 32'd0;
            e.known = 1'b1;
        end else if (BYPASS && we && widx == idx) begin
            e.data  = wdata;
            e.known = 1'b1;
        end else begin
            e.data  = mdlMem[idx];
            e.known = mdlWritten[idx];
        end

        expDone = 1'b0;
        if (inRun) begin
            if (accepted && slc) begin
                runLen = (runLen < 1023) ? runLen + 1 : 1023;
            end else if (!stallNow) begin
                expDone = 1'b1;
                expLen  = runLen;
                inRun   = 1'b0;
            end
        end else if (accepted && slc) begin
            inRun  = 1'b1;
            runLen = 1;
        end

        if (expQ.size() > 0 && !dstall) void'(expQ.pop_front());
        if (accepted) expQ.push_back(e);
        if (we && widx < NE) begin
            mdlMem[widx]     = wdata;
            mdlWritten[widx] = 1'b1;
        end

        @(posedge clock);
        @(negedge clock);
        checkOutput();
    endtask

    task automatic modelReset();
        expQ.delete();
        inRun   = 1'b0;
        runLen  = 0;
        expDone = 1'b0;
    endtask

    initial begin
        bit acc;
        int sent;
        bit pend;
        bit pSlc;
        int pIdx;

        for (int i = 0; i < NE; i++) mdlWritten[i] = 1'b0;
        reset = 1'b0;
        bus.I_Req = 0; bus.I_Slice = 0; bus.I_Index = '0; bus.I_We = 0;
        bus.I_Wr_Index = '0; bus.I_Wr_Data = '0; bus.I_Stall = 0;

        @(negedge clock);
        checkOutput();
        checkVal("rst_data", 64'(bus.O_Data), 64'd0);
        checkVal("rst_index", 64'(bus.O_Index), 64'd0);
        checkVal("rst_slice", 64'(bus.O_Slice), 64'd0);
        checkVal("rst_first", 64'(bus.O_First), 64'd0);
        checkVal("rst_err", 64'(bus.O_Err), 64'd0);
        checkVal("rst_run_len", 64'(bus.O_Run_Len), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        applyStimulus(0, 0, 0, 1, 3, 32'hA5A5_0001, 0, acc);
        applyStimulus(1, 0, 3, 0, 0, 32'd0, 0, acc);
        checkVal("dir_valid3", 64'(bus.O_Valid), 64'd1);
        checkVal("dir_data3", 64'(bus.O_Data), 64'hA5A5_0001);
        checkVal("dir_index3", 64'(bus.O_Index), 64'd3);
        checkVal("dir_first3", 64'(bus.O_First), 64'd0);
        checkVal("dir_err3", 64'(bus.O_Err), 64'd0);
        applyStimulus(0, 0, 0, 0, 0, 32'd0, 0, acc);

        for (int i = 0; i < 32; i++) applyStimulus(0, 0, 0, 1, i, $urandom, 0, acc);

        for (int i = 4; i < 8; i++) begin
            applyStimulus(1, 1, i, 0, 0, 32'd0, 0, acc);
            checkVal("dir_run_first", 64'(bus.O_First), 64'(i == 4));
        end
        applyStimulus(0, 0, 0, 0, 0, 32'd0, 0, acc);
        checkVal("dir_run_done", 64'(bus.O_Run_Done), 64'd1);
        checkVal("dir_run_len", 64'(bus.O_Run_Len), 64'd4);
        applyStimulus(0, 0, 0, 0, 0, 32'd0, 0, acc);
        checkVal("dir_run_pulse", 64'(bus.O_Run_Done), 64'd0);

        sent = 0;
        for (int c = 0; c < 30 && sent < 5; c++) begin
            applyStimulus(1, 0, 10 + sent, 0, 0, 32'd0, (c < 5), acc);
            if (acc) sent++;
            if (c == 2) checkVal("dir_stall_after3", 64'(bus.O_Stall), 64'd1);
            if (c == 4) checkVal("dir_held_head", 64'(bus.O_Index), 64'd10);
        end
        for (int c = 0; c < 6; c++) applyStimulus(0, 0, 0, 0, 0, 32'd0, 0, acc);

        applyStimulus(1, 0, 300, 0, 0, 32'd0, 0, acc);
        checkVal("dir_oor_err", 64'(bus.O_Err), 64'd1);
        checkVal("dir_oor_data", 64'(bus.O_Data), 64'd0);
        applyStimulus(0, 0, 0, 1, 300, 32'hDEAD_BEEF, 0, acc);

        applyStimulus(0, 0, 0, 1, 9, 32'h0000_5555, 0, acc);
        applyStimulus(1, 0, 9, 1, 9, 32'h0000_1234, 0, acc);
        checkVal("dir_bypass", 64'(bus.O_Data), BYPASS ? 64'h1234 : 64'h5555);
        applyStimulus(1, 0, 9, 0, 0, 32'd0, 0, acc);
        checkVal("dir_after_write", 64'(bus.O_Data), 64'h1234);
        applyStimulus(0, 0, 0, 0, 0, 32'd0, 0, acc);

        applyStimulus(1, 1, 20, 0, 0, 32'd0, 1, acc);
        applyStimulus(1, 1, 21, 0, 0, 32'd0, 1, acc);
        #2 reset = 1'b0;
        #1;
        modelReset();
        checkVal("mid_rst_valid", 64'(bus.O_Valid), 64'd0);
        checkVal("mid_rst_stall", 64'(bus.O_Stall), 64'd0);
        checkVal("mid_rst_done", 64'(bus.O_Run_Done), 64'd0);
        bus.I_Req = 0; bus.I_Slice = 0; bus.I_Stall = 0;
        @(negedge clock);
        reset = 1'b1;
        applyStimulus(1, 1, 22, 0, 0, 32'd0, 0, acc);
        checkVal("fresh_first", 64'(bus.O_First), 64'd1);
        applyStimulus(1, 1, 23, 0, 0, 32'd0, 0, acc);
        applyStimulus(0, 0, 0, 0, 0, 32'd0, 0, acc);
        checkVal("fresh_len", 64'(bus.O_Run_Len), 64'd2);

        pend = 0; pSlc = 0; pIdx = 0;
        for (int c = 0; c < 500; c++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                pSlc = ($urandom_range(0, 4) != 0);
                pIdx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(256, 511))
                                                   : int'($urandom_range(0, 31));
            end
            applyStimulus(pend, pSlc, pIdx, ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 15) == 0) ? 300 : int'($urandom_range(0, 31)),
                          $urandom, ($urandom_range(0, 2) == 0), acc);
            if (acc) pend = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
